// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply / restoring divide on operand magnitudes, then one sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;   // negate product / quotient
  logic              neg_rem_q, neg_rem_d;   // negate remainder
  logic              bz_q, bz_d;
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;       // dividend as issued, returned on divide-by-zero
  logic [WIDTH-1:0]  b_q, b_d;               // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;     // product high / partial remainder
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;     // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;

  logic              signed_op;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift, div_diff;
  logic [2*WIDTH-1:0] product;

  assign signed_op = ~op_i[0];
  assign a_mag     = (signed_op && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
  assign b_mag     = (signed_op && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign product   = {acc_hi_q, acc_lo_q};

  // Next-state: accept, iterate, then sign-fix and publish HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bz_d      = bz_q;
    a_raw_d   = a_raw_q;
    b_d       = b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StCalc;
          cnt_d     = '0;
          is_div_d  = op_i[1];
          neg_res_d = signed_op & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
          neg_rem_d = signed_op & op_i[1] & src_a_i[WIDTH-1];
          bz_d      = op_i[1] & (src_b_i == '0);
          a_raw_d   = src_a_i;
          // mult walks the multiplier (src_b) LSB-first; div shifts the dividend out MSB-first
          b_d       = op_i[1] ? b_mag : a_mag;
          acc_lo_d  = op_i[1] ? a_mag : b_mag;
          acc_hi_d  = '0;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        dbz_d   = bz_q;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_res_q ? -product : product;
        end else if (bz_q) begin
          lo_d = '1;
          hi_d = a_raw_q;
        end else begin
          lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      a_raw_q   <= '0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bz_q      <= bz_d;
      a_raw_q   <= a_raw_d;
      b_q       <= b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results, monitor pops on done.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam int Latency = 34;  // drive-time cycle count to done-visible cycle

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .op_i          (op),
    .src_a_i       (src_a),
    .src_b_i       (src_b),
    .busy_o        (busy),
    .done_o        (done),
    .div_by_zero_o (dbz),
    .hi_o          (hi),
    .lo_o          (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference results straight from MIPS arithmetic rules
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_v;
    logic [63:0] p, q, r, ua, ub;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    e.dbz = 1'b0;
    e.cyc = 0;
    case (o)
      2'b00: begin p = 64'(sa * sb_v); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = ua * ub;        e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          q = 64'(sa / sb_v); r = 64'(sa % sb_v);
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Wait (bounded) until idle, then issue one op; optionally poke start mid-operation
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke);
    exp_t e;
    int   guard = 0;
    while (busy) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        $display("FAIL busy_timeout: busy still %0b after %0d cycles", busy, guard);
        $fatal(1, "busy never dropped");
      end
    end
    start = 1'b1; op = o; src_a = a; src_b = b;
    e = model(o, a, b);
    e.cyc = cyc + Latency;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    if (poke) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_by_zero", 64'(dbz), 64'(e.dbz));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_in_done", 64'(busy), 64'(0));
      end
    end
  end

  initial begin
    int guard;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_dbz", 64'(dbz), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b00, 32'd7,        32'hFFFF_FFFD, 1'b1);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2,        1'b0);
    issue(2'b11, 32'd100,      32'd7,        1'b0);
    issue(2'b11, 32'h64,       32'd0,        1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FF00, 32'd0,        1'b0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(2'b10, 32'd7,        32'hFFFF_FFFE, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, ($urandom_range(0, 7) == 0));
    end

    // Reset mid-divide: abort with no done, registers cleared
    issue(2'b11, 32'd1000, 32'd3, 1'b0);
    guard = 0;
    while (busy && guard < 100) begin @(posedge clk); #1; guard++; end
    check("pre_reset_idle", 64'(busy), 64'(0));
    issue(2'b10, 32'h1234_5678, 32'd9, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (40) @(posedge clk);

    // One more op after the abort to show the unit recovers
    #1;
    issue(2'b01, 32'd123456, 32'd789, 1'b0);
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin @(posedge clk); guard++; end
    check("drain", 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
